soc_map_responder: RTL and testbench



---
 rtl/soc_map_responder_pkg.sv | 106 ++++++++++
 rtl/soc_map_responder_if.sv | 41 ++++
 rtl/soc_map_responder_lut.sv | 42 ++++
 rtl/soc_map_responder.sv | 132 +++++++++++++
 tb/tb_soc_map_responder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/soc_map_responder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// soc_map_responder_pkg: SoC slave map, register offsets and FSM state types
// Revision 1.0
// ----------------------------------------------------------------------------
package soc_map_responder_pkg;

  localparam int unsigned NB_PERIPHERALS = 10;

  typedef enum logic [3:0] {
    DRAM     = 4'd0,
    GPIO     = 4'd1,
    Ethernet = 4'd2,
    SPI      = 4'd3,
    Timer    = 4'd4,
    UART     = 4'd5,
    PLIC     = 4'd6,
    CLINT    = 4'd7,
    ROM      = 4'd8,
    Debug    = 4'd9
  } axi_slaves_t;

  typedef enum logic [63:0] {
    DebugBase    = 64'h0000_0000,
    ROMBase      = 64'h0001_0000,
    CLINTBase    = 64'h0200_0000,
    PLICBase     = 64'h0C00_0000,
    UARTBase     = 64'h1000_0000,
    TimerBase    = 64'h1800_0000,
    SPIBase      = 64'h2000_0000,
    EthernetBase = 64'h3000_0000,
    GPIOBase     = 64'h4000_0000,
    DRAMBase     = 64'h8000_0000
  } soc_bus_start_t;

  localparam logic [63:0] DebugLength    = 64'h0000_1000;
  localparam logic [63:0] ROMLength      = 64'h0001_0000;
  localparam logic [63:0] CLINTLength    = 64'h000C_0000;
  localparam logic [63:0] PLICLength     = 64'h03FF_FFFF;
  localparam logic [63:0] UARTLength     = 64'h0000_1000;
  localparam logic [63:0] TimerLength    = 64'h0000_1000;
  localparam logic [63:0] SPILength      = 64'h0080_0000;
  localparam logic [63:0] EthernetLength = 64'h0001_0000;
  localparam logic [63:0] GPIOLength     = 64'h0000_1000;
  localparam logic [63:0] DRAMLength     = 64'h4000_0000;

  localparam logic [63:0] OFFS_NB_PERIPH  = 64'h000;
  localparam logic [63:0] OFFS_WR_COUNT   = 64'h008;
  localparam logic [63:0] OFFS_SLAVE_BASE = 64'h100;
  localparam logic [63:0] OFFS_SLAVE_END  = OFFS_SLAVE_BASE + 64'(16 * NB_PERIPHERALS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_GOT_AW = 2'd1,
    W_GOT_W  = 2'd2,
    W_RESP   = 2'd3
  } w_state_e;

  function automatic logic [63:0] slave_base(input logic [3:0] idx);
    logic [63:0] v;
    v = '0;
    case (idx)
      DRAM:     v = DRAMBase;
      GPIO:     v = GPIOBase;
      Ethernet: v = EthernetBase;
      SPI:      v = SPIBase;
      Timer:    v = TimerBase;
      UART:     v = UARTBase;
      PLIC:     v = PLICBase;
      CLINT:    v = CLINTBase;
      ROM:      v = ROMBase;
      Debug:    v = DebugBase;
      default:  v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] slave_length(input logic [3:0] idx);
    logic [63:0] v;
    v = '0;
    case (idx)
      DRAM:     v = DRAMLength;
      GPIO:     v = GPIOLength;
      Ethernet: v = EthernetLength;
      SPI:      v = SPILength;
      Timer:    v = TimerLength;
      UART:     v = UARTLength;
      PLIC:     v = PLICLength;
      CLINT:    v = CLINTLength;
      ROM:      v = ROMLength;
      Debug:    v = DebugLength;
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/soc_map_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// soc_map_responder_if: AXI4-Lite channel bundle, named from the responder side
// Revision 1.0
// ----------------------------------------------------------------------------
interface soc_map_responder_if #(
  parameter int unsigned AddrWidth = 64
) ();
  logic                 aw_valid_i;
  logic                 aw_ready_o;
  logic [AddrWidth-1:0] aw_addr_i;
  logic                 w_valid_i;
  logic                 w_ready_o;
  logic [63:0]          w_data_i;
  logic [7:0]           w_strb_i;
  logic                 b_valid_o;
  logic                 b_ready_i;
  logic [1:0]           b_resp_o;
  logic                 ar_valid_i;
  logic                 ar_ready_o;
  logic [AddrWidth-1:0] ar_addr_i;
  logic                 r_valid_o;
  logic                 r_ready_i;
  logic [63:0]          r_data_o;
  logic [1:0]           r_resp_o;

  modport slave (
    input  aw_valid_i, aw_addr_i, w_valid_i, w_data_i, w_strb_i, b_ready_i,
           ar_valid_i, ar_addr_i, r_ready_i,
    output aw_ready_o, w_ready_o, b_valid_o, b_resp_o, ar_ready_o,
           r_valid_o, r_data_o, r_resp_o
  );

  modport master (
    output aw_valid_i, aw_addr_i, w_valid_i, w_data_i, w_strb_i, b_ready_i,
           ar_valid_i, ar_addr_i, r_ready_i,
    input  aw_ready_o, w_ready_o, b_valid_o, b_resp_o, ar_ready_o,
           r_valid_o, r_data_o, r_resp_o
  );
endinterface
`default_nettype wire

// File: rtl/soc_map_responder_lut.sv
`default_nettype none
// ----------------------------------------------------------------------------
// soc_map_lut: combinational offset -> {data, resp} lookup of the SoC map
// Revision 1.0
// ----------------------------------------------------------------------------
module soc_map_lut
  import soc_map_responder_pkg::*;
#(
  parameter int unsigned AddrWidth  = 64,
  parameter logic [63:0] WindowSize = 64'h1000
) (
  input  logic [AddrWidth-1:0] i_addr,
  input  logic [31:0]          i_wr_count,
  output logic [63:0]          o_data,
  output logic [1:0]           o_resp
);

  logic [63:0] w_off;
  logic [3:0]  w_idx;

  always_comb begin
    w_off  = 64'(i_addr) & (WindowSize - 64'd1);
    w_idx  = 4'((w_off - OFFS_SLAVE_BASE) >> 4);
    o_data = '0;
    o_resp = RESP_SLVERR;
    if (w_off[2:0] == 3'b000) begin
      if (w_off == OFFS_NB_PERIPH) begin
        o_data = 64'(NB_PERIPHERALS);
        o_resp = RESP_OKAY;
      end else if (w_off == OFFS_WR_COUNT) begin
        o_data = {32'd0, i_wr_count};
        o_resp = RESP_OKAY;
      end else if (w_off >= OFFS_SLAVE_BASE && w_off < OFFS_SLAVE_END) begin
        // Each slave owns a 16-byte slot: base at +0, length at +8.
        o_data = w_off[3] ? slave_length(w_idx) : slave_base(w_idx);
        o_resp = RESP_OKAY;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/soc_map_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// soc_map_responder: read-only AXI4-Lite view of the SoC map; writes get SLVERR
// Revision 1.0
// ----------------------------------------------------------------------------
module soc_map_responder
  import soc_map_responder_pkg::*;
#(
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned DataWidth  = 64,  // only 64 is supported
  parameter logic [63:0] WindowSize = 64'h1000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  soc_map_responder_if.slave bus
);

  r_state_e             r_rstate;
  r_state_e             w_rnext;
  w_state_e             r_wstate;
  w_state_e             w_wnext;
  logic [31:0]          r_wr_count;
  logic [DataWidth-1:0] r_rdata;
  logic [1:0]           r_rresp;
  logic [63:0]          w_lut_data;
  logic [1:0]           w_lut_resp;
  logic                 w_ar_hs;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_wr_inc;
  logic                 w_unused;

  assign w_unused = ^{bus.aw_addr_i, bus.w_data_i, bus.w_strb_i};

  soc_map_lut #(
    .AddrWidth  (AddrWidth),
    .WindowSize (WindowSize)
  ) u_lut (
    .i_addr     (bus.ar_addr_i),
    .i_wr_count (r_wr_count),
    .o_data     (w_lut_data),
    .o_resp     (w_lut_resp)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_rstate <= w_rnext;
      if (w_ar_hs) begin
        r_rdata <= w_lut_data;
        r_rresp <= w_lut_resp;
      end
    end
  end

  always_comb begin
    w_rnext        = r_rstate;
    w_ar_hs        = 1'b0;
    bus.ar_ready_o = 1'b0;
    bus.r_valid_o  = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        bus.ar_ready_o = !rst_i;
        w_ar_hs        = bus.ar_valid_i && !rst_i;
        if (w_ar_hs) w_rnext = R_RESP;
      end
      R_RESP: begin
        bus.r_valid_o = !rst_i;
        if (bus.r_ready_i) w_rnext = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  assign bus.r_data_o = r_rdata;
  assign bus.r_resp_o = r_rresp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate   <= W_IDLE;
      r_wr_count <= '0;
    end else begin
      r_wstate <= w_wnext;
      if (w_wr_inc && (r_wr_count != 32'hFFFF_FFFF)) r_wr_count <= r_wr_count + 32'd1;
    end
  end

  always_comb begin
    w_wnext        = r_wstate;
    w_aw_hs        = 1'b0;
    w_w_hs         = 1'b0;
    bus.aw_ready_o = 1'b0;
    bus.w_ready_o  = 1'b0;
    bus.b_valid_o  = 1'b0;
    bus.b_resp_o   = RESP_OKAY;
    case (r_wstate)
      W_IDLE: begin
        bus.aw_ready_o = !rst_i;
        bus.w_ready_o  = !rst_i;
        w_aw_hs        = bus.aw_valid_i && !rst_i;
        w_w_hs         = bus.w_valid_i && !rst_i;
        if (w_aw_hs && w_w_hs) w_wnext = W_RESP;
        else if (w_aw_hs)      w_wnext = W_GOT_AW;
        else if (w_w_hs)       w_wnext = W_GOT_W;
      end
      W_GOT_AW: begin
        bus.w_ready_o = !rst_i;
        w_w_hs        = bus.w_valid_i && !rst_i;
        if (w_w_hs) w_wnext = W_RESP;
      end
      W_GOT_W: begin
        bus.aw_ready_o = !rst_i;
        w_aw_hs        = bus.aw_valid_i && !rst_i;
        if (w_aw_hs) w_wnext = W_RESP;
      end
      W_RESP: begin
        bus.b_valid_o = !rst_i;
        bus.b_resp_o  = rst_i ? RESP_OKAY : RESP_SLVERR;
        if (bus.b_ready_i) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  // Count write attempts when a response is first raised, not while it waits.
  assign w_wr_inc = (r_wstate != W_RESP) && (w_wnext == W_RESP);

endmodule
`default_nettype wire

// File: tb/tb_soc_map_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_soc_map_responder: directed self-checking bench for soc_map_responder
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_soc_map_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  soc_map_responder_if #(.AddrWidth(64)) bus ();

  soc_map_responder #(
    .AddrWidth  (64),
    .DataWidth  (64),
    .WindowSize (64'h1000)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [63:0] exp_d,
                         input logic [1:0] exp_r, input string tag);
    bus.ar_addr_i  = addr;
    bus.ar_valid_i = 1'b1;
    bus.r_ready_i  = 1'b1;
    #1;
    chk({tag, "/ar_ready"}, 64'(bus.ar_ready_o), 64'd1);
    chk({tag, "/r_valid_pre"}, 64'(bus.r_valid_o), 64'd0);
    tick();
    bus.ar_valid_i = 1'b0;
    #1;
    chk({tag, "/r_valid"}, 64'(bus.r_valid_o), 64'd1);
    chk({tag, "/r_data"}, bus.r_data_o, exp_d);
    chk({tag, "/r_resp"}, 64'(bus.r_resp_o), 64'(exp_r));
    tick();
    chk({tag, "/r_valid_post"}, 64'(bus.r_valid_o), 64'd0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.aw_valid_i = 1'b0;
    bus.aw_addr_i  = '0;
    bus.w_valid_i  = 1'b0;
    bus.w_data_i   = 64'hDEAD_BEEF_0123_4567;
    bus.w_strb_i   = 8'hFF;
    bus.b_ready_i  = 1'b0;
    bus.ar_valid_i = 1'b0;
    bus.ar_addr_i  = '0;
    bus.r_ready_i  = 1'b0;

    // Reset state, with valids asserted on the inputs to prove readies stay low.
    repeat (2) tick();
    bus.ar_valid_i = 1'b1;
    bus.aw_valid_i = 1'b1;
    bus.w_valid_i  = 1'b1;
    #1;
    chk("rst/ar_ready", 64'(bus.ar_ready_o), 64'd0);
    chk("rst/aw_ready", 64'(bus.aw_ready_o), 64'd0);
    chk("rst/w_ready", 64'(bus.w_ready_o), 64'd0);
    chk("rst/r_valid", 64'(bus.r_valid_o), 64'd0);
    chk("rst/b_valid", 64'(bus.b_valid_o), 64'd0);
    chk("rst/r_data", bus.r_data_o, 64'd0);
    chk("rst/r_resp", 64'(bus.r_resp_o), 64'd0);
    chk("rst/b_resp", 64'(bus.b_resp_o), 64'd0);
    bus.ar_valid_i = 1'b0;
    bus.aw_valid_i = 1'b0;
    bus.w_valid_i  = 1'b0;
    rst            = 1'b0;
    #1;
    chk("idle/ar_ready", 64'(bus.ar_ready_o), 64'd1);

    // Map reads.
    do_read(64'h000, 64'd10, 2'b00, "rd_nb");
    do_read(64'h170, 64'h0200_0000, 2'b00, "rd_clint_base");
    do_read(64'h178, 64'h000C_0000, 2'b00, "rd_clint_len");
    do_read(64'h108, 64'h4000_0000, 2'b00, "rd_dram_len");
    do_read(64'h198, 64'h0000_1000, 2'b00, "rd_debug_len");
    do_read(64'hFFFF_0000_0000_1100, 64'h8000_0000, 2'b00, "rd_alias");
    do_read(64'h104, 64'd0, 2'b10, "rd_misaligned");
    do_read(64'h200, 64'd0, 2'b10, "rd_unmapped");
    do_read(64'h1A0, 64'd0, 2'b10, "rd_past_end");
    do_read(64'h008, 64'd0, 2'b00, "rd_cnt0");

    // AW at cycle 0, W at cycle 3, response at cycle 4.
    bus.aw_valid_i = 1'b1;
    #1;
    chk("wr1/aw_ready", 64'(bus.aw_ready_o), 64'd1);
    tick();
    bus.aw_valid_i = 1'b0;
    #1;
    chk("wr1/aw_ready_got_aw", 64'(bus.aw_ready_o), 64'd0);
    chk("wr1/w_ready_got_aw", 64'(bus.w_ready_o), 64'd1);
    tick();
    chk("wr1/b_valid_wait", 64'(bus.b_valid_o), 64'd0);
    tick();
    bus.w_valid_i = 1'b1;
    tick();
    bus.w_valid_i = 1'b0;
    #1;
    chk("wr1/b_valid", 64'(bus.b_valid_o), 64'd1);
    chk("wr1/b_resp", 64'(bus.b_resp_o), 64'd2);
    bus.b_ready_i = 1'b1;
    tick();
    bus.b_ready_i = 1'b0;
    #1;
    chk("wr1/b_valid_done", 64'(bus.b_valid_o), 64'd0);
    do_read(64'h008, 64'd1, 2'b00, "rd_cnt1");

    // Same-cycle AW+W with a stalled response.
    bus.aw_valid_i = 1'b1;
    bus.w_valid_i  = 1'b1;
    tick();
    bus.aw_valid_i = 1'b0;
    bus.w_valid_i  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("wr2/b_valid_hold", 64'(bus.b_valid_o), 64'd1);
      chk("wr2/aw_ready_hold", 64'(bus.aw_ready_o), 64'd0);
      chk("wr2/w_ready_hold", 64'(bus.w_ready_o), 64'd0);
      tick();
    end
    bus.b_ready_i = 1'b1;
    tick();
    bus.b_ready_i = 1'b0;
    #1;
    chk("wr2/b_valid_done", 64'(bus.b_valid_o), 64'd0);
    do_read(64'h008, 64'd2, 2'b00, "rd_cnt2");

    // W before AW.
    bus.w_valid_i = 1'b1;
    tick();
    bus.w_valid_i = 1'b0;
    #1;
    chk("wr3/w_ready_got_w", 64'(bus.w_ready_o), 64'd0);
    chk("wr3/aw_ready_got_w", 64'(bus.aw_ready_o), 64'd1);
    bus.aw_valid_i = 1'b1;
    tick();
    bus.aw_valid_i = 1'b0;
    #1;
    chk("wr3/b_valid", 64'(bus.b_valid_o), 64'd1);
    bus.b_ready_i = 1'b1;
    tick();
    bus.b_ready_i = 1'b0;

    // Counter increment and read of 0x008 on the same edge sees the old value.
    bus.aw_valid_i = 1'b1;
    bus.w_valid_i  = 1'b1;
    bus.b_ready_i  = 1'b1;
    bus.ar_valid_i = 1'b1;
    bus.ar_addr_i  = 64'h008;
    bus.r_ready_i  = 1'b1;
    tick();
    bus.aw_valid_i = 1'b0;
    bus.w_valid_i  = 1'b0;
    bus.ar_valid_i = 1'b0;
    #1;
    chk("race/r_data", bus.r_data_o, 64'd3);
    chk("race/b_valid", 64'(bus.b_valid_o), 64'd1);
    tick();
    bus.b_ready_i = 1'b0;
    do_read(64'h008, 64'd4, 2'b00, "rd_cnt4");

    // Response held stable under backpressure.
    bus.ar_addr_i  = 64'h170;
    bus.ar_valid_i = 1'b1;
    bus.r_ready_i  = 1'b0;
    tick();
    bus.ar_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall/r_valid", 64'(bus.r_valid_o), 64'd1);
      chk("stall/r_data", bus.r_data_o, 64'h0200_0000);
      chk("stall/ar_ready", 64'(bus.ar_ready_o), 64'd0);
      tick();
    end
    bus.r_ready_i = 1'b1;
    tick();
    chk("stall/r_valid_done", 64'(bus.r_valid_o), 64'd0);

    // Reset while a read response is pending.
    bus.ar_addr_i  = 64'h000;
    bus.ar_valid_i = 1'b1;
    bus.r_ready_i  = 1'b0;
    tick();
    bus.ar_valid_i = 1'b0;
    #1;
    chk("mid_rst/r_valid_pre", 64'(bus.r_valid_o), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst/r_valid", 64'(bus.r_valid_o), 64'd0);
    chk("mid_rst/r_data", bus.r_data_o, 64'd0);
    chk("mid_rst/ar_ready", 64'(bus.ar_ready_o), 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst/ar_ready_after", 64'(bus.ar_ready_o), 64'd1);
    chk("mid_rst/r_valid_after", 64'(bus.r_valid_o), 64'd0);
    tick();
    chk("mid_rst/no_late_resp", 64'(bus.r_valid_o), 64'd0);
    do_read(64'h008, 64'd0, 2'b00, "rd_cnt_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
